// File: rtl/rf_pkg.sv
// Shared constants and helpers for the integer register file and its scoreboard.
package rf_pkg;

    localparam int RF_XLEN      = 32;
    localparam int RF_RST_ZERO  = 0;
    localparam int RF_RST_INDEX = 1;

    // Register 0 always resets to zero so it never holds a non-zero value.
    function automatic int rf_reset_value(input int idx, input int mode);
        int val;
        if ((mode == RF_RST_ZERO) || (idx == 0)) begin
            val = 0;
        end else begin
            val = idx;
        end
        return val;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when it writes back.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next-state: a new issue supersedes a same-cycle writeback to the same register.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (iss_en && (iss_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= {NUM_REGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write bypass, busy scoreboard, debug port
// and a saturating writeback counter.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN       = RF_XLEN,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_W     = $clog2(NUM_REGS),
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int RESET_MODE = RF_RST_INDEX
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     hazard,
    output logic [NUM_REGS-1:0]      busy_vec,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [XLEN-1:0]          dbg_data,
    output logic [31:0]              wb_count
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [31:0]     wb_count_q;
    logic [31:0]     wb_count_d;
    logic            wr_accept_s;

    assign wr_accept_s = wr_en && (wr_addr != {ADDR_W{1'b0}});

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    // Storage array; register 0 keeps its zero reset value since writes to it are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= XLEN'(rf_reset_value(i, RESET_MODE));
            end
        end else if (wr_accept_s) begin
            regs_q[wr_addr] <= wr_data;
        end else begin
            regs_q <= regs_q;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              fwd_s;

        assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];
        assign fwd_s  = (BYPASS != 0) && wr_en && (wr_addr == addr_s);

        assign rd_data[k*XLEN +: XLEN] = (addr_s == {ADDR_W{1'b0}}) ? {XLEN{1'b0}} :
                                         fwd_s                      ? wr_data      :
                                                                      regs_q[addr_s];
        // A forwarded result already resolves the dependency for this port.
        assign rd_busy[k] = busy_vec[addr_s] && (addr_s != {ADDR_W{1'b0}}) && !fwd_s;
    end

    assign hazard   = |rd_busy;
    assign dbg_data = (dbg_addr == {ADDR_W{1'b0}}) ? {XLEN{1'b0}} : regs_q[dbg_addr];

    // Saturating increment on every accepted write.
    always_comb begin
        wb_count_d = wb_count_q;
        if (wr_accept_s && (wb_count_q != 32'hFFFF_FFFF)) begin
            wb_count_d = wb_count_q + 32'd1;
        end else begin
            wb_count_d = wb_count_q;
        end
    end

    // Writeback counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_count_q <= 32'd0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (bypass/index-reset and no-bypass/zero-reset)
// checked each cycle against a behavioural model plus directed literal expectations.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  dbg_addr;

    logic [63:0] rd_data_a,  rd_data_b;
    logic [1:0]  rd_busy_a,  rd_busy_b;
    logic        hazard_a,   hazard_b;
    logic [31:0] busy_vec_a, busy_vec_b;
    logic [31:0] dbg_data_a, dbg_data_b;
    logic [31:0] wb_count_a, wb_count_b;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    // Model state, index 0 = instance A (bypass, index reset), 1 = instance B.
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];
    longint      m_cnt  [2];

    regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1), .RESET_MODE(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .rd_busy(rd_busy_a), .hazard(hazard_a),
        .busy_vec(busy_vec_a), .dbg_addr(dbg_addr), .dbg_data(dbg_data_a), .wb_count(wb_count_a)
    );

    regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(0), .RESET_MODE(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .rd_busy(rd_busy_b), .hazard(hazard_b),
        .busy_vec(busy_vec_b), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .wb_count(wb_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural state update: reset, writes, scoreboard set/clear with issue winning.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[c][i]  <= (c == 0) ? 32'(i) : 32'd0;
                    m_busy[c][i] <= 1'b0;
                end
                m_cnt[c] <= 64'd0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (wr_en && wr_addr != 5'd0) begin
                    m_reg[c][wr_addr]  <= wr_data;
                    m_busy[c][wr_addr] <= 1'b0;
                    if (m_cnt[c] < 64'hFFFF_FFFF) m_cnt[c] <= m_cnt[c] + 64'd1;
                end
                if (iss_en && iss_addr != 5'd0) m_busy[c][iss_addr] <= 1'b1;
            end
        end
    end

    function automatic bit fwd(input int c, input logic [4:0] a);
        return (c == 0) && wr_en && (wr_addr == a);
    endfunction

    function automatic logic [31:0] exp_read(input int c, input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (fwd(c, a)) return wr_data;
        return m_reg[c][a];
    endfunction

    function automatic bit exp_busy(input int c, input logic [4:0] a);
        return (a != 5'd0) && m_busy[c][a] && !fwd(c, a);
    endfunction

    task automatic cmp_inst(input int c, input string tag, input logic [63:0] rdd,
                            input logic [1:0] rb, input logic hz, input logic [31:0] bv,
                            input logic [31:0] dd, input logic [31:0] wc);
        logic [4:0]  a;
        logic [1:0]  eb;
        logic [31:0] ev;
        eb = 2'b00;
        for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*5 +: 5];
            check($sformatf("%s rd_data%0d", tag, k), {32'd0, rdd[k*32 +: 32]}, {32'd0, exp_read(c, a)});
            eb[k] = exp_busy(c, a);
        end
        ev = 32'd0;
        for (int i = 1; i < 32; i++) ev[i] = m_busy[c][i];
        check({tag, " rd_busy"},  {62'd0, rb}, {62'd0, eb});
        check({tag, " hazard"},   {63'd0, hz}, {63'd0, (eb != 2'b00)});
        check({tag, " busy_vec"}, {32'd0, bv}, {32'd0, ev});
        check({tag, " dbg_data"}, {32'd0, dd}, {32'd0, (dbg_addr == 5'd0) ? 32'd0 : m_reg[c][dbg_addr]});
        check({tag, " wb_count"}, {32'd0, wc}, m_cnt[c]);
    endtask

    // Per-cycle model comparison on the opposite edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            cmp_inst(0, "A", rd_data_a, rd_busy_a, hazard_a, busy_vec_a, dbg_data_a, wb_count_a);
            cmp_inst(1, "B", rd_data_b, rd_busy_b, hazard_b, busy_vec_b, dbg_data_b, wb_count_b);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = 10'd0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        iss_en = 1'b0; iss_addr = 5'd0; dbg_addr = 5'd5;
        next_cycle();
        #2;
        check("rst dbg5 A", {32'd0, dbg_data_a}, 64'd5);
        check("rst dbg5 B", {32'd0, dbg_data_b}, 64'd0);
        check("rst rd0 A", rd_data_a, 64'd0);
        check("rst busy A", {32'd0, busy_vec_a}, 64'd0);
        check("rst wbcnt A", {32'd0, wb_count_a}, 64'd0);
        check("rst hazard A", {63'd0, hazard_a}, 64'd0);
        cmp_on = 1'b1;
        next_cycle();
        reset = 1'b0;

        // Bypassed write to 3.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd3}; dbg_addr = 5'd3;
        #2;
        check("byp rd0 A", {32'd0, rd_data_a[31:0]}, 64'hDEAD_BEEF);
        check("nobyp rd0 B", {32'd0, rd_data_b[31:0]}, 64'd0);
        check("pre dbg3 A", {32'd0, dbg_data_a}, 64'd3);
        next_cycle();
        wr_en = 1'b0;
        #2;
        check("post dbg3 A", {32'd0, dbg_data_a}, 64'hDEAD_BEEF);
        check("wbcnt1 A", {32'd0, wb_count_a}, 64'd1);

        // Write to register 0 is dropped.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; rd_addr = 10'd0; dbg_addr = 5'd0;
        #2;
        check("r0 bypass A", rd_data_a, 64'd0);
        next_cycle();
        wr_en = 1'b0;
        #2;
        check("r0 dbg A", {32'd0, dbg_data_a}, 64'd0);
        check("r0 wbcnt A", {32'd0, wb_count_a}, 64'd1);

        // Issue to 7, then writeback to 7.
        next_cycle();
        iss_en = 1'b1; iss_addr = 5'd7;
        next_cycle();
        iss_en = 1'b0; rd_addr = {5'd7, 5'd0};
        #2;
        check("busy7 A", {63'd0, rd_busy_a[1]}, 64'd1);
        check("hazard7 A", {63'd0, hazard_a}, 64'd1);
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0077;
        #2;
        check("wb7 busy A", {63'd0, rd_busy_a[1]}, 64'd0);
        check("wb7 busy B", {63'd0, rd_busy_b[1]}, 64'd1);
        check("wb7 hazard B", {63'd0, hazard_b}, 64'd1);
        check("wb7 rd1 A", {32'd0, rd_data_a[63:32]}, 64'h77);
        next_cycle();
        wr_en = 1'b0;
        #2;
        check("post7 busy_vec A", {63'd0, busy_vec_a[7]}, 64'd0);
        check("post7 hazard A", {63'd0, hazard_a}, 64'd0);

        // Same-cycle issue and writeback to 9; issue to 0 is ignored.
        next_cycle();
        iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999_9999;
        next_cycle();
        iss_addr = 5'd0; wr_en = 1'b0; dbg_addr = 5'd9;
        #2;
        check("set wins A", {63'd0, busy_vec_a[9]}, 64'd1);
        check("reg9 A", {32'd0, dbg_data_a}, 64'h9999_9999);
        next_cycle();
        iss_en = 1'b0;
        #2;
        check("iss0 busy_vec A", {32'd0, busy_vec_a}, 64'h0000_0200);

        // Issue to 4, reset before writeback, then writeback after release.
        next_cycle();
        iss_en = 1'b1; iss_addr = 5'd4;
        next_cycle();
        iss_en = 1'b0;
        #2;
        check("busy4 A", {63'd0, busy_vec_a[4]}, 64'd1);
        next_cycle();
        reset = 1'b1;
        #2;
        check("mid rst busy A", {32'd0, busy_vec_a}, 64'd0);
        check("mid rst busy B", {32'd0, busy_vec_b}, 64'd0);
        check("mid rst wbcnt A", {32'd0, wb_count_a}, 64'd0);
        next_cycle();
        reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFE_F00D; dbg_addr = 5'd4;
        next_cycle();
        wr_en = 1'b0;
        #2;
        check("late wb reg4 A", {32'd0, dbg_data_a}, 64'hCAFE_F00D);
        check("late wb wbcnt A", {32'd0, wb_count_a}, 64'd1);

        // Mixed traffic for the per-cycle model comparison.
        for (int i = 1; i <= 12; i++) begin
            next_cycle();
            wr_en    = (i % 3) != 0;
            wr_addr  = 5'((i * 5) % 32);
            wr_data  = 32'h1000_0000 + 32'(i * 32'h0101);
            iss_en   = (i % 2) == 0;
            iss_addr = 5'((i * 7) % 32);
            rd_addr  = {5'((i * 7 + 11) % 32), 5'((i * 5) % 32)};
            dbg_addr = 5'((i * 3) % 32);
        end
        next_cycle();
        wr_en = 1'b0; iss_en = 1'b0;
        next_cycle();
        next_cycle();
        cmp_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-write, two-read integer register file; used by the pipelined core.
- Provides a configurable number of read ports, one write port, and optional write-to-read bypass.
- Adds a per-register busy scoreboard set at issue and cleared at writeback, plus a hazard flag for the decode stage.
- Adds a debug read port and a saturating writeback counter.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers (power of two, >=2).
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override).
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and to the hazard logic.
- RESET_MODE, 1, 0 = registers reset to zero; 1 = register i resets to value i (zero-extended).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]
- wr_en  in  1  writeback enable
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  XLEN  writeback data
- iss_en  in  1  instruction issue with destination; marks the destination busy
- iss_addr  in  ADDR_W  issued destination register
- rd_busy  out  NUM_RD  per-port flag: source register has a pending write
- hazard  out  1  OR of rd_busy over all ports
- busy_vec  out  NUM_REGS  scoreboard state; bit 0 is always 0
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  XLEN  debug read data (no bypass)
- wb_count  out  32  saturating count of accepted writes

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - reg[i] = 0 or i per RESET_MODE; reg[0] = 0 in both modes.
  - busy_vec = 0, wb_count = 0, hazard = 0.
  - rd_data and dbg_data reflect the reset contents combinationally.
- Write: on posedge clk, if wr_en and wr_addr != 0, then reg[wr_addr] <= wr_data. Writes to address 0 are dropped and not counted.
- Register 0 reads as 0 on every port regardless of any other input.
- Read (combinational, zero latency), for port k:
  - addr 0 -> 0.
  - else if BYPASS and wr_en and wr_addr == addr -> wr_data.
  - else reg[addr].
- Scoreboard, per register r != 0, at posedge clk:
  - set when iss_en and iss_addr == r.
  - clear when wr_en and wr_addr == r.
  - set and clear in the same cycle on the same r -> set wins (the new producer supersedes).
  - iss_addr == 0 has no effect.
- rd_busy[k] = busy_vec[rd_addr_k] and rd_addr_k != 0 and not (BYPASS and wr_en and wr_addr == rd_addr_k).
  - With BYPASS = 0, a register being written this cycle still reports busy.
  - hazard = |rd_busy (combinational).
- wb_count increments by 1 on each accepted write (wr_en and wr_addr != 0) and saturates at 32'hFFFF_FFFF.
- Reset asserted mid-operation clears all pending busy bits; an in-flight writeback arriving after reset release is a normal write.
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN default and the reset-mode constants RF_RST_ZERO = 0, RF_RST_INDEX = 1.
  - A function for the reset value of register i.
- One sub-module, rf_scoreboard: busy_vec register plus set/clear logic, shared by the pipelined core's issue stage.
- The storage array, read muxes, bypass logic and wb_count stay in the top module.

Test Plan:
- Reset with RESET_MODE = 1 -> dbg_data at addr 5 = 5, rd_data at addr 0 = 0, busy_vec = 0, wb_count = 0.
- wr_en = 1, wr_addr = 3, wr_data = 32'hDEAD_BEEF, rd_addr0 = 3 in the same cycle -> rd_data0 = DEADBEEF before the edge (BYPASS = 1); dbg_data at addr 3 = DEADBEEF after the edge; wb_count = 1.
- Write 32'h1234 to addr 0 -> reads of addr 0 remain 0, wb_count unchanged.
- iss_en with iss_addr = 7, then rd_addr1 = 7 -> rd_busy[1] = 1, hazard = 1. In the writeback cycle (wr_addr = 7) rd_busy[1] = 0 with BYPASS = 1 and 1 with BYPASS = 0. After the edge busy_vec[7] = 0.
- iss_en and wr_en both targeting addr 9 in the same cycle -> busy_vec[9] = 1 after the edge and reg[9] holds wr_data.
- Issue to addr 4, assert reset for 1 cycle before writeback -> busy_vec = 0 immediately; the later write to addr 4 updates reg[4] and wb_count = 1.
